// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front end: op codes, FSM state encoding
// and small op-decoding helpers.
package mem_access_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_RESP = 2'd1;
  localparam logic [1:0] ST_RMW_MERGE = 2'd2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  function automatic logic is_load(input logic [2:0] op);
    return op <= OP_LHU;
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SB;
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extract/extend a load from a memory word, and
// merge sub-word store data into a word for read-modify-write.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    result   = word;
    merged   = word;
    case (op_size(op))
      SZ_BYTE: begin
        result = is_signed(op) ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
        merged[{lane, 3'b000} +: 8] = data[7:0];
      end
      SZ_HALF: begin
        result = is_signed(op) ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
        if (lane[1]) merged[31:16] = data[15:0];
        else         merged[15:0]  = data[15:0];
      end
      default: begin
        result = word;
        merged = data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between EX/MEM and a word-addressed data memory with
// registered reads and falling-edge writes; sub-word stores use read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned TAG_W     = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [2:0]       ReqOp,
  input  logic [31:0]      ReqAddr,
  input  logic [31:0]      ReqWriteData,
  input  logic [TAG_W-1:0] ReqDest,
  output logic             Done,
  output logic             LoadValid,
  output logic [31:0]      LoadData,
  output logic [TAG_W-1:0] LoadDest,
  output logic             AddrError,
  output logic [31:0]      MemAddress,
  output logic [31:0]      MemWriteData,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      MemReadData
);

  logic [1:0]       state;
  logic [2:0]       cap_op;
  logic [1:0]       cap_lane;
  logic [29:0]      cap_word;
  logic [31:0]      cap_data;
  logic [TAG_W-1:0] cap_dest;
  logic             accept;
  logic             misaligned;
  logic             req_err;
  logic [31:0]      lane_result;
  logic [31:0]      lane_merged;

  always_comb begin
    case (op_size(ReqOp))
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = ReqAddr[0];
      default: misaligned = |ReqAddr[1:0];
    endcase
  end

  assign req_err  = misaligned || (ReqAddr >= 32'(MEM_BYTES));
  assign ReqReady = (state == ST_IDLE) && !Reset;
  assign accept   = ReqValid && ReqReady;

  mem_lane_align u_align (
    .word   (MemReadData),
    .data   (cap_data),
    .lane   (cap_lane),
    .op     (cap_op),
    .result (lane_result),
    .merged (lane_merged)
  );

  // Loads and SB/SH both read in IDLE; only SW writes directly.
  always_comb begin
    MemAddress   = {ReqAddr[31:2], 2'b00};
    MemWriteData = ReqWriteData;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !req_err) begin
          if (ReqOp == OP_SW) MemWrite = 1'b1;
          else                MemRead  = 1'b1;
        end
      end
      ST_LOAD_RESP: MemAddress = {cap_word, 2'b00};
      ST_RMW_MERGE: begin
        MemAddress   = {cap_word, 2'b00};
        MemWriteData = lane_merged;
        MemWrite     = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_IDLE;
      Done      <= 1'b0;
      LoadValid <= 1'b0;
      AddrError <= 1'b0;
      LoadData  <= '0;
      LoadDest  <= '0;
      cap_op    <= '0;
      cap_lane  <= '0;
      cap_word  <= '0;
      cap_data  <= '0;
      cap_dest  <= '0;
    end else begin
      Done      <= 1'b0;
      LoadValid <= 1'b0;
      AddrError <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_op   <= ReqOp;
            cap_lane <= ReqAddr[1:0];
            cap_word <= ReqAddr[31:2];
            cap_data <= ReqWriteData;
            cap_dest <= ReqDest;
            if (req_err) begin
              Done      <= 1'b1;
              AddrError <= 1'b1;
            end else if (is_load(ReqOp)) begin
              state <= ST_LOAD_RESP;
            end else if (ReqOp == OP_SW) begin
              Done <= 1'b1;
            end else begin
              state <= ST_RMW_MERGE;
            end
          end
        end
        ST_LOAD_RESP: begin
          LoadData  <= lane_result;
          LoadDest  <= cap_dest;
          Done      <= 1'b1;
          LoadValid <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_RMW_MERGE: begin
          Done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: registered-read / negedge-write memory
// model plus a byte-array reference of the architectural memory contents.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned TAG_W     = 5;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             ReqValid;
  logic             ReqReady;
  logic [2:0]       ReqOp;
  logic [31:0]      ReqAddr;
  logic [31:0]      ReqWriteData;
  logic [TAG_W-1:0] ReqDest;
  logic             Done;
  logic             LoadValid;
  logic [31:0]      LoadData;
  logic [TAG_W-1:0] LoadDest;
  logic             AddrError;
  logic [31:0]      MemAddress;
  logic [31:0]      MemWriteData;
  logic             MemRead;
  logic             MemWrite;
  logic [31:0]      MemReadData;

  always #5 Clock = ~Clock;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .TAG_W(TAG_W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqOp        (ReqOp),
    .ReqAddr      (ReqAddr),
    .ReqWriteData (ReqWriteData),
    .ReqDest      (ReqDest),
    .Done         (Done),
    .LoadValid    (LoadValid),
    .LoadData     (LoadData),
    .LoadDest     (LoadDest),
    .AddrError    (AddrError),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  // Memory: registered read, write committed on the falling edge.
  logic [31:0] mem_words [64];
  logic [31:0] rd_q;
  int unsigned rd_cnt  = 0;
  int unsigned wr_cnt  = 0;
  int unsigned bad_lsb = 0;

  always @(posedge Clock) if (MemRead) rd_q <= mem_words[MemAddress[7:2]];
  always @(negedge Clock) if (MemWrite) mem_words[MemAddress[7:2]] <= MemWriteData;
  always @(negedge Clock) begin
    if (MemRead)  rd_cnt++;
    if (MemWrite) wr_cnt++;
    if ((MemRead || MemWrite) && MemAddress[1:0] != 2'b00) bad_lsb++;
  end
  assign MemReadData = rd_q;

  // Reference model
  logic [7:0]       ref_bytes [MEM_BYTES];
  logic [31:0]      exp_ld   = '0;
  logic [TAG_W-1:0] exp_dest = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    int unsigned v = 0;
    for (int unsigned k = 0; k < 4; k++) v += int'(ref_bytes[4*w+k]) << (8*k);
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    int unsigned sz = size_of(op);
    longint v = 0;
    for (int unsigned k = 0; k < sz; k++) v += longint'(ref_bytes[a+k]) << (8*k);
    if (op == OP_LB && v >= 128)   v -= 256;
    if (op == OP_LH && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int unsigned sz = size_of(op);
    for (int unsigned k = 0; k < sz; k++) ref_bytes[a+k] = d[8*k +: 8];
  endtask

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [TAG_W-1:0] dest);
    int unsigned sz = size_of(op);
    logic        err, ld;
    int unsigned lat, exp_lat, rd0, wr0;
    logic [31:0] exp_val;
    err     = (addr % sz != 0) || (addr >= MEM_BYTES);
    ld      = (op <= OP_LHU);
    exp_val = (ld && !err) ? ref_load(op, addr) : 32'h0;
    exp_lat = err ? 0 : ((ld || sz < 4) ? 1 : 0);
    lat = 0;
    while (!ReqReady && lat < 4) begin @(posedge Clock); #1; lat++; end
    check_val("req_ready", ReqReady, 1);
    ReqValid = 1'b1; ReqOp = op; ReqAddr = addr; ReqWriteData = data; ReqDest = dest;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    lat = 0;
    while (!Done && lat < 4) begin @(posedge Clock); #1; lat++; end
    check_val("done", Done, 1);
    check_val("latency", lat, exp_lat);
    check_val("addr_error", AddrError, err);
    check_val("load_valid", LoadValid, ld && !err);
    if (ld && !err) begin
      exp_ld   = exp_val;
      exp_dest = dest;
    end
    check_val("load_data", LoadData, exp_ld);
    check_val("load_dest", 32'(LoadDest), 32'(exp_dest));
    check_val("mem_reads", rd_cnt - rd0, (err || op == OP_SW) ? 0 : 1);
    check_val("mem_writes", wr_cnt - wr0, (err || ld) ? 0 : 1);
    if (!ld && !err) ref_store(op, addr, data);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr, d;
    int unsigned r;
    Reset = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqAddr = '0; ReqWriteData = '0; ReqDest = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_val("rst_done", Done, 0);
    check_val("rst_load_valid", LoadValid, 0);
    check_val("rst_addr_error", AddrError, 0);
    check_val("rst_load_data", LoadData, 0);
    check_val("rst_load_dest", 32'(LoadDest), 0);
    check_val("rst_mem_read", MemRead, 0);
    check_val("rst_mem_write", MemWrite, 0);
    check_val("rst_ready_low", ReqReady, 0);
    Reset = 1'b0;
    #1;
    check_val("ready_after_rst", ReqReady, 1);

    for (int unsigned i = 0; i < 64; i++) run_req(OP_SW, 32'(4*i), $urandom, '0);

    run_req(OP_SW, 32'h10, 32'hDEADBEEF, 5'd0);
    run_req(OP_LW, 32'h10, 32'h0, 5'd1);
    check_val("lw_deadbeef", LoadData, 32'hDEADBEEF);

    run_req(OP_SW, 32'h10, 32'h11223344, 5'd0);
    run_req(OP_SB, 32'h13, 32'h000000AA, 5'd0);
    check_val("sb_word", mem_words[4], 32'hAA223344);
    run_req(OP_LB, 32'h13, 32'h0, 5'd2);
    check_val("lb_sext", LoadData, 32'hFFFFFFAA);
    run_req(OP_LBU, 32'h13, 32'h0, 5'd3);
    check_val("lbu_zext", LoadData, 32'h000000AA);

    run_req(OP_SW, 32'h10, 32'h11223344, 5'd0);
    run_req(OP_SH, 32'h12, 32'h00008001, 5'd0);
    check_val("sh_word", mem_words[4], 32'h80013344);
    run_req(OP_LH, 32'h12, 32'h0, 5'd4);
    check_val("lh_sext", LoadData, 32'hFFFF8001);
    run_req(OP_LHU, 32'h12, 32'h0, 5'd5);
    check_val("lhu_zext", LoadData, 32'h00008001);

    run_req(OP_LW, 32'h11, 32'h0, 5'd9);
    run_req(OP_SH, 32'h13, 32'h1234, 5'd9);
    run_req(OP_LW, 32'h100, 32'h0, 5'd9);
    check_val("err_keeps_load_data", LoadData, 32'h00008001);

    // Back-to-back LW, SW, LW with ReqValid held high.
    ReqValid = 1'b1; ReqOp = OP_LW; ReqAddr = 32'h40; ReqDest = 5'd3; ReqWriteData = '0;
    check_val("b2b_rdy_c0", ReqReady, 1);
    @(posedge Clock); #1;
    ReqOp = OP_SW; ReqAddr = 32'h44; ReqWriteData = 32'hCAFE0123;
    check_val("b2b_rdy_c1", ReqReady, 0);
    check_val("b2b_done_c1", Done, 0);
    @(posedge Clock); #1;
    check_val("b2b_done_c2", Done, 1);
    check_val("b2b_lv_c2", LoadValid, 1);
    check_val("b2b_ld_c2", LoadData, ref_load(OP_LW, 32'h40));
    check_val("b2b_rdy_c2", ReqReady, 1);
    @(posedge Clock); #1;
    ref_store(OP_SW, 32'h44, 32'hCAFE0123);
    ReqOp = OP_LW; ReqAddr = 32'h44; ReqDest = 5'd7;
    check_val("b2b_done_c3", Done, 1);
    check_val("b2b_lv_c3", LoadValid, 0);
    check_val("b2b_rdy_c3", ReqReady, 1);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    check_val("b2b_done_c4", Done, 0);
    check_val("b2b_rdy_c4", ReqReady, 0);
    @(posedge Clock); #1;
    check_val("b2b_done_c5", Done, 1);
    check_val("b2b_lv_c5", LoadValid, 1);
    check_val("b2b_ld_c5", LoadData, 32'hCAFE0123);
    check_val("b2b_dest_c5", 32'(LoadDest), 7);
    exp_ld = 32'hCAFE0123; exp_dest = 5'd7;

    for (int unsigned i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom_range(256, 1023);
      else if (r == 1) addr = $urandom;
      else begin
        addr = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) addr = addr - (addr % size_of(op));
      end
      d = $urandom;
      run_req(op, addr, d, 5'($urandom));
    end

    // Reset during the RMW_MERGE cycle of SB 0x20.
    begin
      int unsigned wr0;
      wr0 = wr_cnt;
      ReqValid = 1'b1; ReqOp = OP_SB; ReqAddr = 32'h20; ReqWriteData = 32'h55; ReqDest = '0;
      @(posedge Clock); #1;
      ReqValid = 1'b0;
      Reset = 1'b1;
      @(posedge Clock); #1;
      check_val("rmw_rst_done", Done, 0);
      check_val("rmw_rst_writes", wr_cnt - wr0, 0);
      check_val("rmw_rst_ready_low", ReqReady, 0);
      Reset = 1'b0;
      #1;
      check_val("rmw_rst_ready", ReqReady, 1);
      check_val("rmw_rst_word", mem_words[8], ref_word(8));
      check_val("rmw_rst_load_data", LoadData, 0);
      exp_ld = '0; exp_dest = '0;
    end
    run_req(OP_LW, 32'h20, 32'h0, 5'd1);

    for (int unsigned w = 0; w < 64; w++) check_val("final_mem", mem_words[w], ref_word(w));
    check_val("mem_addr_low_bits", bad_lsb, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
